vx_alu_dispatch_queue: RTL and testbench
========================================

// Module: vx_alu_dispatch_queue
// PURPOSE
//  Elastic request queue between the issue/dispatch stage and the ALU unit. It
//  buffers up to DEPTH packed ALU requests (alu_req_t) and presents them in order
//  on the ALU request handshake. It tracks queued entries per warp so the
//  scheduler can hold a warp with ALU work still pending. No combinational
//  in->out path exists, which breaks timing between dispatch and the ALU.
// PARAMETERS
//  DEPTH       4            queue entries; power of 2, >=2
//  NUM_WARPS   `NUM_WARPS   warps tracked
//  REQ_W       $bits(alu_req_t)  packed request width (uuid,wid,tmask,PC,next_PC,
//                           op_type,op_mod,use_PC,use_imm,imm,tid,rs1/rs2_data,rd,wb)
// PORTS
//  clk           in   1                      clock
//  reset_n       in   1                      async active-low reset
//  flush         in   1                      sync clear of all entries
//  in_valid      in   1                      dispatch request valid
//  in_data       in   REQ_W                  dispatch request payload
//  in_ready      out  1                      queue can accept
//  out_valid     out  1                      ALU request valid
//  out_data      out  REQ_W                  ALU request payload (head entry)
//  out_ready     in   1                      ALU accepts head
//  count         out  clog2(DEPTH+1)         total occupancy
//  warp_pending  out  NUM_WARPS              bit w = warp w has >=1 queued entry
// BEHAVIOUR
//  - reset_n low (async): wr/rd ptrs=0, count=0, all warp counters=0, out_valid=0,
//    warp_pending=0, in_ready=1 on release. Storage is not reset; out_data is
//    don't-care while out_valid=0.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - Pointers are clog2(DEPTH)+1 bits with wrap bit. empty = ptrs equal;
//    full = index equal and wrap bits differ.
//  - in_ready = !full & !flush. When full, in_ready stays 0 even with a
//    same-cycle pop (no pass-through).
//  - out_valid = !empty; out_data = mem[rd_idx], driven from the registered
//    pointer only.
//  - Latency: a push at cycle N is visible on out_valid at N+1 at the earliest.
//  - Simultaneous push+pop (not full, not empty): both pointers advance and count
//    is unchanged.
//  - Per-warp counter cnt[w], width clog2(DEPTH+1). On push it increments for
//    in_data.wid. On pop it decrements for the head entry's wid. If both hit the
//    same warp in one cycle, it is unchanged. warp_pending[w] = (cnt[w]!=0),
//    registered.
//  - flush=1 has priority: next cycle ptrs, count and cnt[] are 0. Push and pop in
//    the flush cycle are discarded (the ALU must ignore out_data in the flush cycle).
//  - Ptr wrap: after DEPTH pushes, index returns to 0 and the wrap bit toggles.
//    Order is preserved across the wrap.
//  - Reset mid-operation: all state is cleared immediately and queued requests are
//    lost.
//  - Assertions (sim): no cnt[] underflow/overflow; sum(cnt)==count;
//    in_data.wid < NUM_WARPS on push.
// STRUCTURE
//  - vx_alu_pkg holds: alu_req_t packed struct, ALU_REQ_W localparam, and the
//    wid/op field widths shared with the ALU unit.
//  - One sub-module: vx_alu_warp_tracker (cnt[] array and warp_pending), with
//    push_wid/push_en/pop_wid/pop_en/flush inputs. Storage and pointers stay in top.
// TESTING
//  1 Reset: hold reset_n=0 with in_valid=1 -> in_ready=1 after release;
//    out_valid=0, count=0, warp_pending=0.
//  2 Fill/drain: DEPTH=4, push wid 0,1,2,3 with out_ready=0 -> after 4 pushes
//    count=4, in_ready=0, warp_pending=4'b1111. Then out_ready=1 -> pops in order
//    0,1,2,3; count reaches 0 after 4 cycles.
//  3 Full + pop: queue full, in_valid=1, out_ready=1 -> cycle 1 pop only (in_ready=0,
//    count=3). Next cycle push accepted with in_ready=1.
//  4 Same-warp push+pop: head wid=2, push wid=2, pop same cycle -> cnt[2] unchanged
//    and warp_pending[2] stays 1.
//  5 Wrap: stream 10 requests with random out_ready -> out order equals in order;
//    PC field matches per request; no drops or duplicates.
//  6 Flush: 3 entries queued, flush=1 with in_valid=1 -> next cycle count=0,
//    out_valid=0, warp_pending=0; flush-cycle request not stored.

Source files
------------

// File: rtl/vx_alu_pkg.sv
// Shared ALU request format and field widths used by dispatch and the ALU unit.
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif

package vx_alu_pkg;

  localparam int NUM_WARPS_DFLT = `NUM_WARPS;
  localparam int NUM_THREADS    = 4;
  localparam int XLEN           = 32;
  localparam int UUID_W         = 16;
  localparam int WID_W          = (NUM_WARPS_DFLT > 1) ? $clog2(NUM_WARPS_DFLT) : 1;
  localparam int TID_W          = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int OP_TYPE_W      = 4;
  localparam int OP_MOD_W       = 3;
  localparam int NR_W           = 5;

  typedef struct packed {
    logic [UUID_W-1:0]                 uuid;
    logic [WID_W-1:0]                  wid;
    logic [NUM_THREADS-1:0]            tmask;
    logic [XLEN-1:0]                   PC;
    logic [XLEN-1:0]                   next_PC;
    logic [OP_TYPE_W-1:0]              op_type;
    logic [OP_MOD_W-1:0]               op_mod;
    logic                              use_PC;
    logic                              use_imm;
    logic [XLEN-1:0]                   imm;
    logic [TID_W-1:0]                  tid;
    logic [NUM_THREADS-1:0][XLEN-1:0]  rs1_data;
    logic [NUM_THREADS-1:0][XLEN-1:0]  rs2_data;
    logic [NR_W-1:0]                   rd;
    logic                              wb;
  } alu_req_t;

  localparam int ALU_REQ_W = $bits(alu_req_t);

endpackage

// File: rtl/vx_alu_warp_tracker.sv
// Per-warp count of queued ALU requests; warp_pending lets the scheduler hold a warp.
module vx_alu_warp_tracker
  import vx_alu_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int NUM_WARPS = NUM_WARPS_DFLT,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              flush,
  input  logic                              push_en,
  input  logic [WID_W-1:0]                  push_wid,
  input  logic                              pop_en,
  input  logic [WID_W-1:0]                  pop_wid,
  output logic [NUM_WARPS-1:0][CNT_W-1:0]   cnt,
  output logic [NUM_WARPS-1:0]              warp_pending
);

  logic [NUM_WARPS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_WARPS-1:0]            pend_q, pend_d;
  logic [NUM_WARPS-1:0]            inc, dec;

  always_comb begin
    cnt_d  = cnt_q;
    pend_d = '0;
    inc    = '0;
    dec    = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      inc[w] = push_en && (push_wid == WID_W'(w));
      dec[w] = pop_en  && (pop_wid  == WID_W'(w));
      // same-warp push+pop cancels out
      if (flush)
        cnt_d[w] = '0;
      else
        cnt_d[w] = cnt_q[w] + CNT_W'(inc[w]) - CNT_W'(dec[w]);
      pend_d[w] = (cnt_d[w] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      pend_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign cnt          = cnt_q;
  assign warp_pending = pend_q;

`ifndef SYNTHESIS
  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_chk
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(dec[w] && !inc[w] && !flush && cnt_q[w] == '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(inc[w] && !dec[w] && !flush && cnt_q[w] == CNT_W'(DEPTH)));
  end
`endif

endmodule

// File: rtl/vx_alu_dispatch_queue.sv
// Registered FIFO between dispatch and the ALU; no combinational in->out path.
module vx_alu_dispatch_queue
  import vx_alu_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int NUM_WARPS = NUM_WARPS_DFLT,
  parameter int REQ_W     = ALU_REQ_W,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [REQ_W-1:0]      in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [REQ_W-1:0]      out_data,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      count,
  output logic [NUM_WARPS-1:0]  warp_pending
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             empty, full, push, pop;
  alu_req_t         in_req, head;
  alu_req_t         mem_q [DEPTH];
  logic [NUM_WARPS-1:0][CNT_W-1:0] warp_cnt;

  assign in_req = alu_req_t'(in_data);
  assign wr_idx = wr_ptr_q[IDX_W-1:0];
  assign rd_idx = rd_ptr_q[IDX_W-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_idx == rd_idx) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);

  // a slot freed by a pop is only reusable next cycle
  assign in_ready  = !full && !flush;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // payload storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_idx] <= in_req;
  end

  assign head     = mem_q[rd_idx];
  assign out_data = head;
  assign count    = count_q;

  vx_alu_warp_tracker #(
    .DEPTH     (DEPTH),
    .NUM_WARPS (NUM_WARPS)
  ) u_tracker (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .push_en      (push),
    .push_wid     (in_req.wid),
    .pop_en       (pop),
    .pop_wid      (head.wid),
    .cnt          (warp_cnt),
    .warp_pending (warp_pending)
  );

`ifndef SYNTHESIS
  int cnt_sum;
  always_comb begin
    cnt_sum = 0;
    for (int w = 0; w < NUM_WARPS; w++) cnt_sum += int'(warp_cnt[w]);
  end

  a_cnt_sum: assert property (@(posedge clk) disable iff (!reset_n)
    cnt_sum == int'(count_q));
  a_wid_range: assert property (@(posedge clk) disable iff (!reset_n)
    push |-> (int'(in_req.wid) < NUM_WARPS));
`endif

endmodule

// File: tb/tb_vx_alu_dispatch_queue.sv
// Directed bench for the ALU dispatch queue: fill/drain, full, warp tracking, wrap, flush, reset.
module tb_vx_alu_dispatch_queue;
  import vx_alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int NW    = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 flush;
  logic                 in_valid;
  logic [ALU_REQ_W-1:0] in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [ALU_REQ_W-1:0] out_data;
  logic                 out_ready;
  logic [CW-1:0]        count;
  logic [NW-1:0]        warp_pending;
  alu_req_t             ov;

  int n_cmp = 0;
  int n_bad = 0;

  assign ov = alu_req_t'(out_data);

  always #5 clk = ~clk;

  vx_alu_dispatch_queue #(.DEPTH(DEPTH), .NUM_WARPS(NW), .REQ_W(ALU_REQ_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .count        (count),
    .warp_pending (warp_pending)
  );

  function automatic logic [ALU_REQ_W-1:0] mk(input int w, input logic [31:0] pc);
    alu_req_t r;
    logic [31:0] wv;
    wv        = w;
    r         = '0;
    r.wid     = wv[WID_W-1:0];
    r.PC      = pc;
    r.next_PC = pc + 32'd4;
    r.uuid    = pc[15:0];
    r.tmask   = 4'hf;
    r.wb      = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = mk(0, 32'h10);
    repeat (3) tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL rst_count got %0d exp 0", count); end
    reset_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %0b exp 1", in_ready); end
    n_cmp++; if (warp_pending !== 4'b0000) begin n_bad++; $display("FAIL rst_pending got %b exp 0000", warp_pending); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rel_out_valid got %0b exp 0", out_valid); end
    in_valid = 1'b0;
  endtask

  task automatic test_fill_drain();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = mk(i, 32'h100 + 32'(i * 4));
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL fill_count got %0d exp 4", count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_in_ready got %0b exp 0", in_ready); end
    n_cmp++; if (warp_pending !== 4'b1111) begin n_bad++; $display("FAIL fill_pending got %b exp 1111", warp_pending); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || ov.wid !== WID_W'(i) || ov.PC !== 32'h100 + 32'(i * 4)) begin
        n_bad++; $display("FAIL drain_%0d got v=%0b wid=%0d pc=%h exp wid=%0d pc=%h",
                          i, out_valid, ov.wid, ov.PC, i, 32'h100 + 32'(i * 4));
      end
      tick();
      n_cmp++; if (count !== CW'(3 - i)) begin n_bad++; $display("FAIL drain_count_%0d got %0d exp %0d", i, count, 3 - i); end
    end
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL drain_out_valid got %0b exp 0", out_valid); end
    n_cmp++; if (warp_pending !== 4'b0000) begin n_bad++; $display("FAIL drain_pending got %b exp 0000", warp_pending); end
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = mk(i, 32'h200 + 32'(i * 4));
      tick();
    end
    in_data   = mk(1, 32'h300);
    out_ready = 1'b1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready got %0b exp 0", in_ready); end
    tick();
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL full_pop_count got %0d exp 3", count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL full_pop_in_ready got %0b exp 1", in_ready); end
    n_cmp++; if (warp_pending !== 4'b1110) begin n_bad++; $display("FAIL full_pop_pending got %b exp 1110", warp_pending); end
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_push_count got %0d exp 4", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] epc;
      epc = (i == 3) ? 32'h300 : 32'h204 + 32'(i * 4);
      n_cmp++;
      if (out_valid !== 1'b1 || ov.PC !== epc) begin
        n_bad++; $display("FAIL full_drain_%0d got v=%0b pc=%h exp pc=%h", i, out_valid, ov.PC, epc);
      end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (count !== '0 || warp_pending !== 4'b0000) begin
      n_bad++; $display("FAIL full_empty got count=%0d pend=%b exp 0/0000", count, warp_pending);
    end
  endtask

  task automatic test_same_warp();
    in_valid = 1'b1; in_data = mk(2, 32'h400); out_ready = 1'b0;
    tick();
    n_cmp++; if (warp_pending !== 4'b0100) begin n_bad++; $display("FAIL sw_pend0 got %b exp 0100", warp_pending); end
    in_data = mk(2, 32'h404); out_ready = 1'b1;
    tick();
    n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL sw_count got %0d exp 1", count); end
    n_cmp++; if (warp_pending !== 4'b0100) begin n_bad++; $display("FAIL sw_pend got %b exp 0100", warp_pending); end
    n_cmp++; if (ov.PC !== 32'h404) begin n_bad++; $display("FAIL sw_head got %h exp 00000404", ov.PC); end
    in_data = mk(3, 32'h408);
    tick();
    n_cmp++; if (warp_pending !== 4'b1000 || count !== 3'd1) begin
      n_bad++; $display("FAIL xw_pend got pend=%b count=%0d exp 1000/1", warp_pending, count);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (warp_pending !== 4'b0000 || count !== '0) begin
      n_bad++; $display("FAIL sw_empty got pend=%b count=%0d exp 0000/0", warp_pending, count);
    end
  endtask

  task automatic test_wrap();
    int nin, nout, cyc;
    logic p_push, p_pop;
    nin = 0; nout = 0; cyc = 0;
    while ((nout < 10) && (cyc < 200)) begin
      in_valid  = (nin < 10);
      in_data   = mk(nin % 4, 32'h1000 + 32'(nin * 4));
      out_ready = 1'($urandom_range(0, 1));
      p_push = in_valid && in_ready;
      p_pop  = out_valid && out_ready;
      if (p_pop) begin
        n_cmp++;
        if (ov.PC !== 32'h1000 + 32'(nout * 4) || ov.wid !== WID_W'(nout % 4)) begin
          n_bad++; $display("FAIL wrap_%0d got pc=%h wid=%0d exp pc=%h wid=%0d",
                            nout, ov.PC, ov.wid, 32'h1000 + 32'(nout * 4), nout % 4);
        end
        nout++;
      end
      if (p_push) nin++;
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (nout !== 10) begin n_bad++; $display("FAIL wrap_total got %0d exp 10", nout); end
    n_cmp++; if (count !== '0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL wrap_empty got count=%0d v=%0b exp 0/0", count, out_valid);
    end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; out_ready = 1'b0;
    in_data = mk(0, 32'h500); tick();
    in_data = mk(1, 32'h504); tick();
    in_data = mk(3, 32'h508); tick();
    n_cmp++; if (count !== 3'd3 || warp_pending !== 4'b1011) begin
      n_bad++; $display("FAIL fl_pre got count=%0d pend=%b exp 3/1011", count, warp_pending);
    end
    flush = 1'b1; in_data = mk(2, 32'h600); out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fl_in_ready got %0b exp 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (count !== '0 || out_valid !== 1'b0 || warp_pending !== 4'b0000) begin
      n_bad++; $display("FAIL fl_clear got count=%0d v=%0b pend=%b exp 0/0/0000", count, out_valid, warp_pending);
    end
    tick();
    n_cmp++; if (count !== '0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL fl_stored got count=%0d v=%0b exp 0/0", count, out_valid);
    end
    in_valid = 1'b1; in_data = mk(1, 32'h700);
    tick();
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd1 || ov.PC !== 32'h700 || warp_pending !== 4'b0010) begin
      n_bad++; $display("FAIL fl_after got count=%0d pc=%h pend=%b exp 1/00000700/0010", count, ov.PC, warp_pending);
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_data = mk(2, 32'h800); out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL rm_pre got %0d exp 2", count); end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++; if (count !== '0 || out_valid !== 1'b0 || warp_pending !== 4'b0000) begin
      n_bad++; $display("FAIL rm_clear got count=%0d v=%0b pend=%b exp 0/0/0000", count, out_valid, warp_pending);
    end
    tick();
    reset_n = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rm_rel got rdy=%0b v=%0b exp 1/0", in_ready, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_pop();
    test_same_warp();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
